// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder:
// 4-bit group generate/propagate, in-group carries, and parameter legality.
package cla_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // WIDTH must split into whole segments, and each segment into whole 4-bit groups.
   function automatic logic cfg_legal(input int width, input int seg);
      return (seg >= 4) && (seg % 4 == 0) && (width >= seg) && (width % seg == 0);
   endfunction

   function automatic gp_t grp_gp(input logic [3:0] g, input logic [3:0] p);
      gp_t r;
      r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      r.p = &p;
      return r;
   endfunction

   // Carries into bits 0..3 of a group, flattened two-level form.
   function automatic logic [3:0] grp_carry(input logic [2:0] g, input logic [2:0] p,
                                            input logic c0);
      logic [3:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead segment built from 4-bit groups with a
// group-level lookahead; exports segment generate/propagate for the caller.
module cla_seg
   import cla_pkg::*;
#(
   parameter int SEG = 16
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b_eff,
   input  logic           c_in,
   output logic [SEG-1:0] s,
   output logic           c_out,
   output logic           g,
   output logic           p
);
   localparam int NGRP = SEG / 4;

   logic [SEG-1:0]  w_bg, w_bp, w_c;
   logic [NGRP-1:0] w_gg, w_gp;
   logic [NGRP:0]   w_gc;

   assign w_bg = a & b_eff;
   assign w_bp = a | b_eff;

   always_comb begin
      w_gg = '0;
      w_gp = '0;
      for (int j = 0; j < NGRP; j++) begin
         {w_gg[j], w_gp[j]} = grp_gp(w_bg[4*j +: 4], w_bp[4*j +: 4]);
      end
   end

   // NOTE: blocking assignments here are intentional; each group carry reads the one just computed.
   always_comb begin
      w_gc    = '0;
      w_gc[0] = c_in;
      for (int j = 0; j < NGRP; j++) begin
         w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
      end
   end

   always_comb begin
      w_c = '0;
      for (int j = 0; j < NGRP; j++) begin
         w_c[4*j +: 4] = grp_carry(w_bg[4*j +: 3], w_bp[4*j +: 3], w_gc[j]);
      end
   end

   always_comb begin
      g = 1'b0;
      p = 1'b1;
      for (int j = 0; j < NGRP; j++) begin
         g = w_gg[j] | (w_gp[j] & g);
         p = p & w_gp[j];
      end
   end

   assign s     = a ^ b_eff ^ w_c;
   assign c_out = w_gc[NGRP];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment resolves per
// stage; inter-segment carry and the pending upper operand segments are registered.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int NSTG = WIDTH / SEG;
   localparam int LAST = NSTG - 1;

   if (!cfg_legal(WIDTH, SEG)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a multiple of SEG, SEG a multiple of 4 and >= 4");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             r_a_msb, r_b_msb;

   assign w_adv    = out_ready | ~out_valid;
   assign in_ready = w_adv;
   assign w_b_eff  = sub ? ~b : b;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int DONE = k * SEG;
      localparam int REM  = WIDTH - DONE;

      logic                w_vld_in, w_c_in;
      logic [REM-1:0]      w_a_in, w_b_in;
      logic [DONE+SEG-1:0] w_sum_nxt;
      logic [SEG-1:0]      w_s;
      logic                w_c_out, w_seg_g, w_seg_p;
      logic                r_vld, r_c;
      logic [DONE+SEG-1:0] r_sum;

      if (k == 0) begin : g_src
         assign w_vld_in  = in_valid;
         assign w_c_in    = sub | cin;
         assign w_a_in    = a;
         assign w_b_in    = w_b_eff;
         assign w_sum_nxt = w_s;
      end else begin : g_src
         assign w_vld_in  = g_stg[k-1].r_vld;
         assign w_c_in    = g_stg[k-1].r_c;
         assign w_a_in    = g_stg[k-1].g_skew.r_a;
         assign w_b_in    = g_stg[k-1].g_skew.r_b;
         assign w_sum_nxt = {w_s, g_stg[k-1].r_sum};
      end

      cla_seg #(.SEG(SEG)) u_seg (
         .a     (w_a_in[SEG-1:0]),
         .b_eff (w_b_in[SEG-1:0]),
         .c_in  (w_c_in),
         .s     (w_s),
         .c_out (w_c_out),
         .g     (w_seg_g),
         .p     (w_seg_p)
      );

      // The segment's carry chain and its lookahead terms must describe the same carry.
      always_comb assert (w_c_out == (w_seg_g | (w_seg_p & w_c_in)));

      // NOTE: only the valid bit is reset; payload of an invalid stage is don't-care and outputs are gated by valid.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)        r_vld <= 1'b0;
         else if (w_adv) r_vld <= w_vld_in;
      end

      always_ff @(posedge clk) begin
         if (w_adv) begin
            r_c   <= w_c_out;
            r_sum <= w_sum_nxt;
         end
      end

      if (k < LAST) begin : g_skew
         logic [REM-SEG-1:0] r_a, r_b;
         always_ff @(posedge clk) begin
            if (w_adv) begin
               r_a <= w_a_in[REM-1:SEG];
               r_b <= w_b_in[REM-1:SEG];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_a_msb <= g_stg[LAST].w_a_in[SEG-1];
         r_b_msb <= g_stg[LAST].w_b_in[SEG-1];
      end
   end

   assign out_valid = g_stg[LAST].r_vld;
   assign sum       = out_valid ? g_stg[LAST].r_sum : '0;
   assign cout      = out_valid & g_stg[LAST].r_c;
   assign ovf       = out_valid & (r_a_msb == r_b_msb) & (g_stg[LAST].r_sum[WIDTH-1] != r_a_msb);
   assign zero      = out_valid & ~|g_stg[LAST].r_sum;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=32, SEG=16): directed vectors, backpressure,
// mid-stream reset and a random soak against an arithmetic reference model.
module tb_cla_pipe_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] a, b;
   logic        cin, sub;
   logic        out_valid, out_ready;
   logic [31:0] sum;
   logic        cout, ovf, zero;

   cla_pipe_adder #(.WIDTH(32), .SEG(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a, b;
      logic        cin, sub;
      logic [31:0] sum;
      logic        cout, ovf, zero;
   } vec_t;

   typedef struct packed {
      logic [31:0] a, b;
      logic        cin, sub;
   } beat_t;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_out  = 0;
   beat_t       pend[$];
   logic [34:0] exp_q[$];
   logic        hold_v = 1'b0;
   logic [34:0] hold_o;
   vec_t        vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: plain wide arithmetic; signed range test for overflow.
   function automatic logic [34:0] model(input beat_t bt);
      logic [32:0] u;
      longint      s;
      logic        c, o;
      if (bt.sub) begin
         u = {1'b0, bt.a} - {1'b0, bt.b};
         s = longint'($signed(bt.a)) - longint'($signed(bt.b));
         c = ~u[32];
      end else begin
         u = {1'b0, bt.a} + {1'b0, bt.b} + {32'd0, bt.cin};
         s = longint'($signed(bt.a)) + longint'($signed(bt.b)) + longint'(bt.cin);
         c = u[32];
      end
      o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return {c, o, (u[31:0] == 32'd0), u[31:0]};
   endfunction

   task automatic single(input vec_t v, input string tag);
      @(negedge clk);
      in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom;
      check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_sum"},   64'(sum),  64'(v.sum));
      check({tag, "_cout"},  64'(cout), 64'(v.cout));
      check({tag, "_ovf"},   64'(ovf),  64'(v.ovf));
      check({tag, "_zero"},  64'(zero), 64'(v.zero));
   endtask

   // One clock of streaming: drive the pending head, score both handshakes.
   task automatic cycle(input logic ordy, input logic gap);
      @(negedge clk);
      if (hold_v) check("stall_hold", {28'd0, out_valid, cout, ovf, zero, sum}, {28'd0, 1'b1, hold_o});
      out_ready = ordy;
      if (pend.size() > 0 && !gap) begin
         in_valid = 1'b1; a = pend[0].a; b = pend[0].b; cin = pend[0].cin; sub = pend[0].sub;
      end else begin
         in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      end
      #1;
      hold_v = out_valid & ~out_ready;
      hold_o = {cout, ovf, zero, sum};
      if (hold_v) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) check("unexpected_out", 64'(sum), 64'hDEAD_0000_0000);
         else check("stream_out", 64'({cout, ovf, zero, sum}), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(pend[0]));
         void'(pend.pop_front());
      end
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{32'h00010000, 32'h00000001, 1'b0, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum",       64'(sum),       64'd0);
      check("rst_cout",      64'(cout),      64'd0);
      check("rst_ovf",       64'(ovf),       64'd0);
      check("rst_zero",      64'(zero),      64'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 11; i++) single(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: out_ready pattern 1,0,0,1 repeating.
      hold_v = 1'b0;
      n_out  = 0;
      for (int i = 0; i < 8; i++) pend.push_back('{32'(i), 32'(i), 1'b0, 1'b0});
      for (int c = 0; c < 200 && (pend.size() > 0 || exp_q.size() > 0); c++)
         cycle((c % 4 == 0) || (c % 4 == 3), 1'b0);
      check("bp_drained", 64'(pend.size() + exp_q.size()), 64'd0);
      check("bp_count",   64'(n_out), 64'd8);

      // Reset with two beats in flight.
      hold_v = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      a = 32'h33; b = 32'h44;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("midrst_pre_valid", 64'(out_valid), 64'd1);
      check("midrst_pre_sum",   64'(sum),       64'h33);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_sum",       64'(sum),       64'd0);
      check("midrst_zero",      64'(zero),      64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("postrst_in_ready",  64'(in_ready),  64'd1);
      check("postrst_out_valid", 64'(out_valid), 64'd0);
      single(vecs[2], "postrst");

      // Random soak.
      hold_v = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 10000; i++)
         pend.push_back('{32'($urandom), 32'($urandom), 1'($urandom), 1'($urandom)});
      for (int c = 0; c < 60000 && (pend.size() > 0 || exp_q.size() > 0); c++)
         cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      check("soak_drained", 64'(pend.size() + exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
